// File: rtl/bin_frame_unpack_if.sv
// Stream interface for bin_frame_unpack: narrow word input plus whole-frame output.
// master = word producer / frame consumer side, slave = the unpacker.
interface bin_frame_unpack_if #(
    parameter int SUM_WIDTH = 32,
    parameter int BINS      = 4,
    parameter int N_OUT     = 8
);
    logic                           in_valid;
    logic                           in_ready;
    logic [N_OUT-1:0]               in_data;
    logic                           in_last;
    logic                           out_valid;
    logic                           out_ready;
    logic [BINS-1:0][SUM_WIDTH-1:0] out_data;
    logic                           frame_err;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, frame_err
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, frame_err
    );
endinterface

// File: rtl/bin_frame_unpack.sv
// Reassembles N_OUT-bit words into frames of BINS x SUM_WIDTH bin sums, with framing-error resync.
// Optional counters frame_cnt/err_cnt are enabled by defining BIN_FRAME_UNPACK_STATS_EN.
module bin_frame_unpack #(
    parameter int SUM_WIDTH = 32,
    parameter int BINS      = 4,
    parameter int N_OUT     = 8
) (
    input  logic                 clk,
    input  logic                 srst_n,
    bin_frame_unpack_if.slave    bus
`ifdef BIN_FRAME_UNPACK_STATS_EN
    ,
    output logic [15:0]          frame_cnt,
    output logic [15:0]          err_cnt
`endif
);
    localparam int W     = SUM_WIDTH / N_OUT;
    localparam int WORDS = BINS * W;
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    generate
        if (SUM_WIDTH % N_OUT != 0) begin : g_width_check
            $error("bin_frame_unpack: SUM_WIDTH must be a multiple of N_OUT");
        end
    endgenerate

    typedef enum logic [1:0] {FILL, FULL, HUNT} state_t;

    state_t                         state, state_nx;
    logic [CNT_W-1:0]               cnt, cnt_nx;
    logic [CNT_W-1:0]               slot;
    logic [WORDS-1:0][N_OUT-1:0]    asm_q, asm_nx;
    logic [BINS-1:0][SUM_WIDTH-1:0] out_q;
    logic                           out_valid_q, out_valid_nx;
    logic                           frame_err_q, err_nx;
    logic                           load;
    logic                           in_fire, out_fire, at_end;

    assign bus.in_ready  = (state != FULL);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_q;
    assign bus.frame_err = frame_err_q;

    assign in_fire  = bus.in_valid && (state != FULL);
    assign out_fire = out_valid_q && bus.out_ready;
    assign at_end   = (cnt == CNT_W'(WORDS - 1));

    // Word k lands in bin k/W, MSB slice first; in the flat packed view that is
    // word index (k/W)*W + (W-1-k%W).
    assign slot = CNT_W'((int'(cnt) / W) * W + (W - 1 - int'(cnt) % W));

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        asm_nx       = asm_q;
        load         = 1'b0;
        err_nx       = 1'b0;
        out_valid_nx = out_valid_q && !out_fire;

        unique case (state)
            FILL: begin
                if (in_fire) begin
                    asm_nx[slot] = bus.in_data;
                    if (at_end && bus.in_last) begin
                        cnt_nx = '0;
                        if (!out_valid_q || out_fire) load = 1'b1;
                        else                          state_nx = FULL;
                    end else if (bus.in_last) begin
                        err_nx = 1'b1;
                        cnt_nx = '0;
                    end else if (at_end) begin
                        err_nx   = 1'b1;
                        cnt_nx   = '0;
                        state_nx = HUNT;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            end
            FULL: begin
                if (out_fire) begin
                    load     = 1'b1;
                    state_nx = FILL;
                end
            end
            HUNT: begin
                if (in_fire && bus.in_last) begin
                    state_nx = FILL;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = FILL;
        endcase

        if (load) out_valid_nx = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state       <= FILL;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            out_valid_q <= out_valid_nx;
            frame_err_q <= err_nx;
            if (load) out_q <= asm_nx;
        end
    end

    // NOTE: the assembly register is not reset; every slice is rewritten before a frame completes.
    always_ff @(posedge clk) begin
        asm_q <= asm_nx;
    end

`ifdef BIN_FRAME_UNPACK_STATS_EN
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (out_fire && frame_cnt != 16'hFFFF)   frame_cnt <= frame_cnt + 16'd1;
            if (frame_err_q && err_cnt != 16'hFFFF)  err_cnt   <= err_cnt + 16'd1;
        end
    end
`endif

endmodule
